// File: rtl/disp_pingpong_buf_if.sv
// ---------------------------------------------------------------------------
// disp_pingpong_buf_if
//   Bundles the producer write handshake, the frame/hold controls and the
//   mux-facing outputs of disp_pingpong_buf.
//
//   Signals:
//     wr_valid   producer -> buffer  word present on wr_data
//     wr_data    producer -> buffer  word for the hidden bank
//     wr_ready   buffer -> producer  buffer can accept a word this cycle
//     frame_tick producer -> buffer  one-cycle frame boundary pulse
//     hold       producer -> buffer  defers any pending swap while high
//     bank0      buffer -> mux I0    bank 0 contents
//     bank1      buffer -> mux I1    bank 1 contents
//     sel        buffer -> mux s     visible bank index
//     swap_pulse buffer -> observer  high for the cycle after sel changes
//     swap_cnt   buffer -> observer  completed swaps, modulo 256
//
//   Modports:
//     master : the producer / observer side
//     slave  : the buffer itself
// ---------------------------------------------------------------------------
interface disp_pingpong_buf_if #(
  parameter int WIDTH = 32
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             frame_tick;
  logic             hold;
  logic [WIDTH-1:0] bank0;
  logic [WIDTH-1:0] bank1;
  logic             sel;
  logic             swap_pulse;
  logic [7:0]       swap_cnt;

  modport master (
    output wr_valid, wr_data, frame_tick, hold,
    input  wr_ready, bank0, bank1, sel, swap_pulse, swap_cnt
  );

  modport slave (
    input  wr_valid, wr_data, frame_tick, hold,
    output wr_ready, bank0, bank1, sel, swap_pulse, swap_cnt
  );
endinterface

// File: rtl/disp_pingpong_buf.sv
// ---------------------------------------------------------------------------
// disp_pingpong_buf
//   Double-buffered word store feeding a 2:1 display mux. Each accepted word
//   goes into the hidden bank (~sel); the bank select then flips so the
//   consumer switches to the new word atomically.
//
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   synchronous active-high reset (discards any pending word)
//     bus  slave modport of disp_pingpong_buf_if (handshake, frame_tick,
//          hold, bank0/bank1/sel mux drives, swap_pulse, swap_cnt)
//
//   Build option:
//     PINGPONG_FRAME_SYNC_EN  when defined, a pending word is published only
//                             on a frame_tick (tear-free display). When
//                             undefined, it is published on the cycle after
//                             acceptance and frame_tick is unused.
// ---------------------------------------------------------------------------
module disp_pingpong_buf #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  disp_pingpong_buf_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,   // no pending swap
    PEND = 1'b1    // hidden bank holds an unpublished word
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sel;
  logic        r_swap_pulse;
  logic [7:0]  r_swap_cnt;

  logic        w_accept;
  logic        w_swap;
  logic        w_swap_cond;
  logic        w_wr_ready;

`ifndef PINGPONG_FRAME_SYNC_EN
  // frame_tick has no effect in the free-running build.
  logic        w_unused_tick;
  assign w_unused_tick = bus.frame_tick;
`endif

  // ---------------------------------------------------------------------
  // Next-state / handshake decode
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_wr_ready   = 1'b0;
    w_accept     = 1'b0;
    w_swap       = 1'b0;
`ifdef PINGPONG_FRAME_SYNC_EN
    w_swap_cond  = bus.frame_tick;
`else
    w_swap_cond  = 1'b1;
`endif
    case (r_state)
      IDLE: begin
        // Ticks arriving here are dropped; a tick in the acceptance cycle
        // therefore never publishes the word being accepted.
        w_wr_ready = 1'b1;
        if (bus.wr_valid) begin
          w_accept     = 1'b1;
          w_state_next = PEND;
        end
      end
      PEND: begin
        // wr_valid is ignored here; the producer holds until wr_ready.
        if (w_swap_cond && !bus.hold) begin
          w_swap       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Bank registers: bank gi is written only while it is hidden (sel != gi)
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [WIDTH-1:0] r_word;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_word <= '0;
        end else if (w_accept && (r_sel != 1'(gi))) begin
          r_word <= bus.wr_data;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Select, swap pulse and swap counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel        <= 1'b0;
      r_swap_pulse <= 1'b0;
      r_swap_cnt   <= 8'd0;
    end else begin
      // Registered alongside sel, so it is high exactly during the first
      // cycle in which the new sel value is visible.
      r_swap_pulse <= w_swap;
      if (w_swap) begin
        r_sel      <= ~r_sel;
        r_swap_cnt <= r_swap_cnt + 8'd1;   // wraps 255 -> 0
      end
    end
  end

  assign bus.wr_ready   = w_wr_ready;
  assign bus.bank0      = g_bank[0].r_word;
  assign bus.bank1      = g_bank[1].r_word;
  assign bus.sel        = r_sel;
  assign bus.swap_pulse = r_swap_pulse;
  assign bus.swap_cnt   = r_swap_cnt;

endmodule

// File: doc/disp_pingpong_buf.md
# disp_pingpong_buf

Double-buffered 32-bit word store that sits directly upstream of the 32-bit 2:1 display/data multiplexer. Accepts words from a producer (CPU I/O write path or game logic) over a valid/ready handshake, writes each into the currently hidden bank, then flips the bank select so the downstream mux shows the new word atomically. Drives the mux's `I0`, `I1` and `s` inputs directly, so the consumer never sees a half-updated word.

## Interface
- `WIDTH`, 32, data word width of both banks and the write port.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  producer has a word on `wr_data`.
- `wr_data`  in  WIDTH  word to load into the hidden bank.
- `wr_ready`  out  1  block can accept a word this cycle.
- `frame_tick`  in  1  one-cycle pulse marking a display frame boundary.
- `hold`  in  1  freeze: defers any pending swap while high.
- `bank0`  out  WIDTH  bank 0 contents; connects to mux `I0`.
- `bank1`  out  WIDTH  bank 1 contents; connects to mux `I1`.
- `sel`  out  1  visible bank index; connects to mux `s`.
- `swap_pulse`  out  1  high for exactly the cycle after `sel` changes.
- `swap_cnt`  out  8  number of completed swaps, modulo 256.

## Operation
- Hidden bank is always `~sel`. Writes never touch the visible bank.
- FSM states:
  - `IDLE`: no pending swap.
  - `PEND`: hidden bank holds an unpublished word.
- `wr_ready` is combinational: 1 in `IDLE`, 0 in `PEND`.
- `IDLE` with `wr_valid`: load `wr_data` into the hidden bank at the edge, go to `PEND`.
- `PEND` with swap condition true and `hold`=0: at the edge, `sel` <= `~sel`, `swap_cnt` += 1, `swap_pulse` <= 1, go to `IDLE`.
- `PEND` with `hold`=1: stay in `PEND`. Bank contents and `sel` are unchanged.
- Swap condition is set by configuration (see below).
- `swap_cnt` wraps 255 -> 0 silently.
- `frame_tick` in `IDLE` is ignored. Ticks are not remembered.
- `wr_valid` in `PEND` is ignored. The producer must hold data until `wr_ready`=1.
- Reset values (after the edge with `rst`=1):
  - `bank0`=`bank1`=0, `sel`=0, `swap_pulse`=0, `swap_cnt`=0, state `IDLE`, so `wr_ready`=1.
- Reset mid-operation wins over everything. A pending word is discarded.

## Timing
- Write acceptance: 1 edge. The bank register updates at the edge where `wr_valid`&`wr_ready`.
- Earliest swap: the edge after acceptance. In that case `sel` flips 2 edges after `wr_valid` was first sampled.
- `swap_pulse` is registered. It is high in the cycle following the `sel` change and low otherwise.
- `wr_ready` returns to 1 in the same cycle `sel` shows the new value.
- Back-to-back throughput: without the sync feature, one word per 2 cycles.
- All outputs except `wr_ready` are registered. The downstream mux adds no latency.

## Configuration
- Macro: `PINGPONG_FRAME_SYNC_EN`.
- Defined: the swap condition is `frame_tick`=1 in `PEND`, so swaps happen only on frame boundaries (tear-free display).
  - Tick and write acceptance in the same cycle: that tick does not swap, because the state is still `IDLE`.
- Undefined: the swap condition is always true, and `PEND` lasts exactly one cycle unless `hold`=1. The `frame_tick` input is unused.

## Test plan
- Reset: assert `rst` for 2 cycles with `wr_valid`=1 -> `bank0`=`bank1`=0, `sel`=0, `swap_cnt`=0, `wr_ready`=1, nothing is written.
- Single write, no sync: `wr_data`=0x12345678 accepted at `sel`=0 -> next edge `bank1`=0x12345678, following edge `sel`=1, then `swap_pulse`=1 for one cycle, `swap_cnt`=1, `bank0` unchanged.
- Sync mode: accept 0xDEADBEEF, then hold `frame_tick` low for 10 cycles -> `wr_ready`=0 and `sel` unchanged throughout. Pulse `frame_tick` -> `sel` flips at that edge, `wr_ready`=1.
- `hold` interaction: word pending and `hold`=1 across 3 ticks (sync) or 3 cycles (no sync) -> no swap. Drop `hold` -> swap at the next qualifying edge.
- Wrap and ignore: perform 257 write+swap cycles -> `swap_cnt`=1, `sel`=1. `wr_valid` asserted during `PEND` does not corrupt the hidden or visible bank.
- Reset mid-operation: `rst` asserted while in `PEND` -> `sel`=0, banks=0, state `IDLE`, no `swap_pulse`.
